// File: rtl/fft_bin_accumulator.sv
// fft_bin_accumulator
//   Reduces one streamed FFT frame to NUM_BINS display bins (per-bin max of a
//   saturated |re|+|im| magnitude), applies peak-hold decay and publishes the
//   result into a display buffer only on frame_sync so bars never tear.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  sample handshake; in_ready drops while a committed
//                      frame waits for frame_sync
//   in_re, in_im       signed FFT sample
//   in_last            last sample of a frame (commits the frame)
//   frame_sync         start of vertical blanking (swap point)
//   freq_pos_needed    display bin requested
//   freq_value         registered value of the requested bin (1 clk latency)
//   frame_done         one-cycle pulse when the display buffer is updated
module fft_bin_accumulator #(
  parameter int unsigned N_IN      = 128,
  parameter int unsigned NUM_BINS  = 10,
  parameter int unsigned IN_W      = 16,
  parameter int unsigned MAG_SHIFT = 4,
  parameter int unsigned DECAY     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_re,
  input  logic signed [IN_W-1:0] in_im,
  input  logic                   in_last,
  input  logic                   frame_sync,
  input  logic [7:0]             freq_pos_needed,
  output logic [11:0]            freq_value,
  output logic                   frame_done
);

  localparam int unsigned IW = $clog2(N_IN);
  localparam int unsigned GW = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  // idx can reach N_IN (IW+1 bits); NUM_BINS fits in GW bits
  localparam int unsigned PW = IW + 1 + GW;

  typedef enum logic {ACCUM, PENDING} state_t;

  state_t      r_state;
  logic        r_ready;
  logic        r_done;
  logic        r_fresh;
  logic [11:0] r_val;
  logic [IW:0] r_idx;
  logic [11:0] r_pend [NUM_BINS];
  logic [11:0] r_disp [NUM_BINS];

  logic [IN_W-1:0] w_abs_re;
  logic [IN_W-1:0] w_abs_im;
  logic [IN_W:0]   w_mag;
  logic [31:0]     w_shift;
  logic [11:0]     w_scaled;
  logic [PW-1:0]   w_prod;
  logic [GW-1:0]   w_grp;
  logic            w_in_range;
  logic            w_acc;
  logic [11:0]     w_rd;
  logic [11:0]     w_pend_nxt [NUM_BINS];
  logic [11:0]     w_disp_nxt [NUM_BINS];

  assign in_ready   = r_ready;
  assign freq_value = r_val;
  assign frame_done = r_done;

  assign w_acc = in_valid && r_ready;

  // two's-complement negate of the most negative value yields 2^(IN_W-1) as unsigned
  assign w_abs_re = in_re[IN_W-1] ? IN_W'(-in_re) : IN_W'(in_re);
  assign w_abs_im = in_im[IN_W-1] ? IN_W'(-in_im) : IN_W'(in_im);
  assign w_mag    = {1'b0, w_abs_re} + {1'b0, w_abs_im};
  assign w_shift  = 32'(w_mag) >> MAG_SHIFT;
  assign w_scaled = (w_shift > 32'd4095) ? 12'hFFF : w_shift[11:0];

  assign w_in_range = (r_idx < (IW+1)'(N_IN));
  assign w_prod     = PW'(r_idx) * PW'(NUM_BINS);
  assign w_grp      = GW'(w_prod >> IW);

  always_comb begin
    for (int unsigned k = 0; k < NUM_BINS; k++) begin
      // the first sample after a swap starts from a cleared pending buffer
      w_pend_nxt[k] = r_fresh ? '0 : r_pend[k];
      if (w_in_range && (32'(w_grp) == k) && (w_scaled > w_pend_nxt[k]))
        w_pend_nxt[k] = w_scaled;
      w_disp_nxt[k] = (r_disp[k] > 12'(DECAY)) ? (r_disp[k] - 12'(DECAY)) : '0;
      if (r_pend[k] > w_disp_nxt[k])
        w_disp_nxt[k] = r_pend[k];
    end
  end

  always_comb begin
    w_rd = '0;
    for (int unsigned k = 0; k < NUM_BINS; k++) begin
      if (freq_pos_needed == 8'(k))
        w_rd = r_disp[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_fresh <= 1'b1;
      r_val   <= '0;
      r_idx   <= '0;
      for (int unsigned k = 0; k < NUM_BINS; k++) begin
        r_pend[k] <= '0;
        r_disp[k] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      r_val  <= w_rd;
      case (r_state)
        ACCUM: begin
          if (w_acc) begin
            r_fresh <= 1'b0;
            for (int unsigned k = 0; k < NUM_BINS; k++)
              r_pend[k] <= w_pend_nxt[k];
            if (in_last) begin
              r_idx   <= '0;
              r_state <= PENDING;
              r_ready <= 1'b0;
            end else if (w_in_range) begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        PENDING: begin
          if (frame_sync) begin
            for (int unsigned k = 0; k < NUM_BINS; k++)
              r_disp[k] <= w_disp_nxt[k];
            r_done  <= 1'b1;
            r_fresh <= 1'b1;
            r_state <= ACCUM;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ACCUM;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_bin_accumulator.sv
// Self-checking bench for fft_bin_accumulator: frame-level reference model
// plus directed literal checks and a randomized phase.
module tb_fft_bin_accumulator;
  localparam int N_IN      = 128;
  localparam int NUM_BINS  = 10;
  localparam int MAG_SHIFT = 4;
  localparam int DECAY     = 64;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_last = 1'b0;
  logic               frame_sync = 1'b0;
  logic signed [15:0] in_re = '0;
  logic signed [15:0] in_im = '0;
  logic [7:0]         freq_pos_needed = '0;
  logic               in_ready;
  logic               frame_done;
  logic [11:0]        freq_value;

  always #5 clk = ~clk;

  fft_bin_accumulator #(
    .N_IN(N_IN), .NUM_BINS(NUM_BINS), .IN_W(16), .MAG_SHIFT(MAG_SHIFT), .DECAY(DECAY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_last(in_last), .frame_sync(frame_sync),
    .freq_pos_needed(freq_pos_needed), .freq_value(freq_value), .frame_done(frame_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model (frame level) ----------------
  int q_frame[$];
  int committed[NUM_BINS];
  int m_disp[NUM_BINS];
  bit m_ready = 1'b1;
  bit m_done  = 1'b0;
  int m_val   = 0;

  function automatic int scaled(input int re, input int im);
    int a, b, s;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    s = (a + b) >> MAG_SHIFT;
    return (s > 4095) ? 4095 : s;
  endfunction

  function automatic void commit_frame();
    for (int k = 0; k < NUM_BINS; k++) committed[k] = 0;
    for (int i = 0; i < q_frame.size() && i < N_IN; i++) begin
      int g;
      g = (i * NUM_BINS) / N_IN;
      if (q_frame[i] > committed[g]) committed[g] = q_frame[i];
    end
    q_frame.delete();
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ready = 1'b1; m_done = 1'b0; m_val = 0;
      q_frame.delete();
      for (int k = 0; k < NUM_BINS; k++) begin committed[k] = 0; m_disp[k] = 0; end
    end else begin
      bit was_ready;
      was_ready = m_ready;
      m_val  = (freq_pos_needed < NUM_BINS) ? m_disp[freq_pos_needed] : 0;
      m_done = 1'b0;
      if (was_ready) begin
        if (in_valid) begin
          q_frame.push_back(scaled(int'(in_re), int'(in_im)));
          if (in_last) begin commit_frame(); m_ready = 1'b0; end
        end
      end else if (frame_sync) begin
        for (int k = 0; k < NUM_BINS; k++) begin
          int d;
          d = m_disp[k] - DECAY;
          if (d < 0) d = 0;
          m_disp[k] = (committed[k] > d) ? committed[k] : d;
        end
        m_done = 1'b1;
        m_ready = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("in_ready", in_ready, m_ready);
    check("frame_done", frame_done, m_done);
    check("freq_value", freq_value, m_val);
  end

  // ---------------- stimulus ----------------
  int fr_re[160];
  int fr_im[160];

  function automatic void clear_frame();
    for (int i = 0; i < 160; i++) begin fr_re[i] = 0; fr_im[i] = 0; end
  endfunction

  task automatic idle(input int n, input int sync_odds);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; in_re = '0; in_im = '0;
      frame_sync = (sync_odds > 0) ? ($urandom_range(0, sync_odds - 1) == 0) : 1'b0;
      freq_pos_needed = 8'($urandom_range(0, 12));
    end
  endtask

  task automatic send_frame(input int n, input bit rnd, input bit sync_on_last, input bit no_last);
    for (int i = 0; i < n; i++) begin
      bit took;
      int budget;
      took = 1'b0;
      budget = 0;
      if (rnd && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 16);
      while (!took) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_re = 16'(fr_re[i]);
        in_im = 16'(fr_im[i]);
        in_last = !no_last && (i == n - 1);
        frame_sync = rnd ? ($urandom_range(0, 15) == 0) : (sync_on_last && i == n - 1);
        freq_pos_needed = ($urandom_range(0, 9) == 0) ? 8'd200 : 8'($urandom_range(0, 11));
        took = in_ready;
        budget++;
        if (!took && budget > 2000) begin
          n_checks++;
          $display("FAIL stall_timeout: in_ready stayed 0 for %0d cycles, expected 1", budget);
          return;
        end
      end
    end
  endtask

  task automatic sync_pulse(input logic exp_done);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; frame_sync = 1'b1;
    @(posedge clk);
    #1;
    check("frame_done_lit", frame_done, exp_done);
  endtask

  task automatic read_lit(input int k, input int exp);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; frame_sync = 1'b0;
    freq_pos_needed = 8'(k);
    @(posedge clk);
    #1;
    check($sformatf("read_bin%0d", k), freq_value, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; frame_sync = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // reset state and empty buffer reads
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("ready_after_reset", in_ready, 1);
    for (int k = 0; k < NUM_BINS; k++) read_lit(k, 0);
    read_lit(200, 0);

    // single tone into group 1
    clear_frame();
    fr_re[20] = -1600; fr_im[20] = 800;
    send_frame(128, 0, 0, 0);
    idle(2, 0);
    check("ready_pending", in_ready, 0);
    sync_pulse(1);
    check("model_disp1", m_disp[1], 150);
    read_lit(1, 150);
    read_lit(0, 0);
    read_lit(2, 0);

    // saturation into group 0
    fr_re[0] = 32767; fr_im[0] = -32768;
    send_frame(128, 0, 0, 0);
    idle(1, 0);
    sync_pulse(1);
    check("model_disp0", m_disp[0], 4095);
    read_lit(0, 4095);
    read_lit(1, 150);

    // peak-hold decay over zero frames
    clear_frame();
    send_frame(128, 0, 0, 0); idle(1, 0); sync_pulse(1);
    read_lit(0, 4031); read_lit(1, 86);
    send_frame(128, 0, 0, 0); idle(1, 0); sync_pulse(1);
    read_lit(0, 3967); read_lit(1, 22);
    send_frame(128, 0, 0, 0); idle(1, 0); sync_pulse(1);
    read_lit(0, 3903); read_lit(1, 0);

    // in_last coincident with frame_sync: commit only, swap waits
    clear_frame();
    fr_im[127] = -3200;
    send_frame(128, 0, 1, 0);
    @(posedge clk); #1;
    check("done_on_coincident", frame_done, 0);
    check("ready_after_commit", in_ready, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_last = 1'b0; frame_sync = 1'b0; in_re = 16'sd20000; in_im = '0;
      check("stall_held_valid", in_ready, 0);
    end
    sync_pulse(1);
    read_lit(9, 200);
    read_lit(0, 3839);

    // reset while PENDING discards the committed frame
    clear_frame();
    fr_re[40] = 8000;
    send_frame(128, 0, 0, 0);
    idle(2, 0);
    do_reset();
    sync_pulse(0);
    read_lit(3, 0);
    read_lit(9, 0);

    // randomized phase
    for (int f = 0; f < 40; f++) begin
      int n;
      int sel;
      for (int i = 0; i < 160; i++) begin
        sel = $urandom_range(0, 7);
        if (sel == 0) begin
          fr_re[i] = int'($urandom_range(0, 65535)) - 32768;
          fr_im[i] = int'($urandom_range(0, 65535)) - 32768;
        end else if (sel <= 2) begin
          fr_re[i] = int'($urandom_range(0, 6000)) - 3000;
          fr_im[i] = int'($urandom_range(0, 6000)) - 3000;
        end else begin
          fr_re[i] = 0; fr_im[i] = 0;
        end
      end
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 150) : 128;
      if ($urandom_range(0, 9) == 0) begin
        send_frame(n, 1, 0, 1);
        do_reset();
      end else begin
        send_frame(n, 1, 0, 0);
        idle($urandom_range(1, 20), 6);
      end
    end
    idle(30, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_bin_accumulator.md
Name: fft_bin_accumulator

Overview:
- Upstream neighbour of the spectrum bar display stage.
- Consumes the streaming FFT magnitude output for one frame and reduces it to NUM_BINS display bins using a per-bin max.
- Applies a peak-hold decay and holds the results in a display buffer that only changes on frame_sync, so bars never tear mid-frame.
- Serves the display's bin requests: freq_pos_needed in, freq_value out.

Parameters:
- N_IN, 128, FFT bins per frame; power of two; index width log2(N_IN).
- NUM_BINS, 10, display bins; must be ≤ N_IN.
- IN_W, 16, signed width of in_re and in_im.
- MAG_SHIFT, 4, right shift applied to the magnitude before saturation to 12 bits.
- DECAY, 64, peak-hold decrement applied per committed frame.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  FFT sample valid
- in_ready  out  1  block accepts a sample this cycle
- in_re  in  IN_W  signed real part
- in_im  in  IN_W  signed imaginary part
- in_last  in  1  marks the last sample of an FFT frame
- frame_sync  in  1  one-cycle pulse at the start of VGA vertical blanking
- freq_pos_needed  in  8  display bin requested
- freq_value  out  12  registered value of the requested bin
- frame_done  out  1  one-cycle pulse when the display buffer is updated

Behaviour:
- Decided: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state ACCUM, in_ready=1, freq_value=0, frame_done=0, sample index=0, all pending and display entries=0.
- Transfer: a sample is accepted when in_valid && in_ready.
- Magnitude per accepted sample:
  - mag = |re| + |im|, 17-bit unsigned; |-32768| = 32768.
  - scaled = mag >> MAG_SHIFT, saturated to 4095.
- Group mapping: g = (idx * NUM_BINS) >> log2(N_IN). With defaults, idx 0..12 → g0, idx 13..25 → g1, ..., idx 116..127 → g9.
- Accumulation: pend[g] <= max(pend[g], scaled). Pending entries are cleared to 0 when a new frame starts, i.e. on the first accepted sample after a swap.
- Index counter: increments on each accepted sample.
  - Samples with idx ≥ N_IN are ignored; the counter saturates at N_IN.
  - Accepting in_last resets the index to 0.
- FSM ACCUM: in_ready=1. An accepted in_last commits the frame: state → PENDING on the next cycle. The last sample is itself included in pend.
- FSM PENDING: in_ready=0; upstream stalls. On frame_sync:
  - for every k, disp[k] <= max(pend[k], sat_sub(disp[k], DECAY)), floored at 0;
  - frame_done pulses in that same update cycle;
  - state → ACCUM.
- Simultaneous in_last and frame_sync while in ACCUM: the commit happens, but the swap waits for the next frame_sync.
- frame_sync while in ACCUM (no committed frame): ignored; disp unchanged; no decay.
- Short frame (in_last before idx N_IN-1): commits normally; groups that received no samples stay 0 in pend.
- Read port:
  - freq_value <= disp[freq_pos_needed] every cycle; latency is 1 clk.
  - freq_pos_needed ≥ NUM_BINS → freq_value <= 0.
  - A read in the swap cycle returns the old value; the new value appears the next cycle.
- Reset mid-frame or mid-PENDING: everything returns to reset values immediately; the partial frame is discarded.

Test Plan:
- Reset, then read bins 0..9 and 200 → freq_value 0 for every bin, 1 cycle after each request; in_ready=1.
- Frame of 128 samples with re=0, im=0 except idx 20: re=-1600, im=800 (mag 2400 → 150); then frame_sync → disp[1]=150, all others 0; frame_done pulses once.
- Same frame but idx 0: re=32767, im=-32768 → scaled 65535>>4 = 4095 (saturated) → disp[0]=4095.
- After the previous case, an all-zero frame, then frame_sync → disp[0]=4031 and disp[1] stays 150 decay→86; a further zero frame → 3967 and 22; the following frame → 22 floors to 0.
- in_last at idx 127 in the same cycle as frame_sync → no update that cycle; in_ready=0 until the next frame_sync; a held in_valid is not accepted while stalled.
- Assert rst_n low while in PENDING with pend[3]=500 → after release, disp[3]=0; the next frame_sync has no effect until a new frame commits.
